// File: rtl/rv_pkg.sv
// Shared RV32 execute-stage types: shift opcode, FSM states and the latched
// request fields of the shift unit.
package rv_pkg;
  localparam int XLEN    = 32;
  localparam int SHAMT_W = 5;

  typedef enum logic [1:0] {
    SLL = 2'd0,
    SRL = 2'd1,
    SRA = 2'd2
  } shift_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shift_state_e;

  // Fields captured at accept; op kept raw so encoding 3 falls through as SLL
  typedef struct packed {
    logic [1:0]         op;
    logic               sign;
    logic [SHAMT_W-1:0] shamt;
  } shift_req_t;
endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Request/result handshake bundle between the ID/EX operand latch and the
// shift unit, plus the result side towards the EX/MEM mux.
interface shift_seq_ctrl_if;
  import rv_pkg::*;
  logic               valid_i;
  logic               ready_o;
  logic [1:0]         op_i;
  logic [XLEN-1:0]    a_i;
  logic [SHAMT_W-1:0] shamt_i;
  logic               kill_i;
  logic               valid_o;
  logic               ready_i;
  logic [XLEN-1:0]    result_o;
  logic               busy_o;

  modport master (
    output valid_i, op_i, a_i, shamt_i, kill_i, ready_i,
    input  ready_o, valid_o, result_o, busy_o
  );
  modport slave (
    input  valid_i, op_i, a_i, shamt_i, kill_i, ready_i,
    output ready_o, valid_o, result_o, busy_o
  );
endinterface

// File: rtl/decode_dif.sv
// Thermometer decoder: shamt N -> N low-order ones (SRA sign-fill mask).
module decode_dif (
  input  logic [4:0]  N_i,
  output logic [31:0] Y_o
);
  for (genvar k = 0; k < 32; k++) begin : g_therm
    assign Y_o[k] = ({27'd0, N_i} > 32'(k));
  end
endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle RV32I shifter: moves the operand up to STEP bits per cycle and
// ORs in the SRA sign fill once, from the reversed thermometer mask.
module shift_seq_ctrl
  import rv_pkg::*;
#(
  parameter int STEP = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  shift_seq_ctrl_if.slave bus
);
  localparam logic [SHAMT_W-1:0] STEP_W = SHAMT_W'(STEP);

  shift_state_e       state, state_nxt;
  logic [XLEN-1:0]    acc, acc_sh;
  logic [SHAMT_W-1:0] rem, s;
  shift_req_t         req;
  logic               accept, do_shift;
  logic [XLEN-1:0]    mask, mask_rev, fill;

  decode_dif u_mask (.N_i(req.shamt), .Y_o(mask));

  for (genvar k = 0; k < XLEN; k++) begin : g_rev
    assign mask_rev[k] = mask[XLEN-1-k];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      acc   <= '0;
      rem   <= '0;
      req   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        acc <= bus.a_i;
        rem <= bus.shamt_i;
        req <= '{op: bus.op_i, sign: bus.a_i[XLEN-1], shamt: bus.shamt_i};
      end else if (do_shift) begin
        acc <= acc_sh;
        rem <= rem - s;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    do_shift  = 1'b0;
    s         = (rem < STEP_W) ? rem : STEP_W;
    acc_sh    = (req.op == SRL || req.op == SRA) ? (acc >> s) : (acc << s);
    fill      = (req.op == SRA && req.sign) ? mask_rev : '0;
    case (state)
      IDLE: begin
        // a flush in the same cycle suppresses the accept
        if (bus.valid_i && !bus.kill_i) begin
          accept    = 1'b1;
          state_nxt = (bus.shamt_i == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (bus.kill_i) begin
          state_nxt = IDLE;
        end else begin
          do_shift = 1'b1;
          if (rem == s) state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.kill_i || bus.ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    bus.ready_o  = (state == IDLE);
    bus.busy_o   = (state != IDLE);
    bus.valid_o  = (state == DONE);
    bus.result_o = acc | fill;
  end
endmodule
